hub75_scan_seq: RTL

//  Row scan sequencer for HUB75 panels; successor of the single-shot row scanner.

---
 rtl/hub75_scan_seq_pkg.sv | 23 ++
 rtl/hub75_scan_seq_if.sv | 29 ++
 rtl/hub75_row_seq.sv | 116 +++++++++++
 rtl/hub75_scan_seq.sv | 123 ++++++++++++
 4 files changed

// File: rtl/hub75_scan_seq_pkg.sv
// rtl/hub75_scan_seq_pkg.sv - shared definitions for the HUB75 row scan sequencer
//
// Purpose : FSM state encodings shared by the hub75 blocks, plus the
//           control bundle passed from the top-level FSM to the row sequencer.
// Contents: ST_IDLE..ST_PAINT (2-bit state codes), row_ctrl_t.
// Config  : HUB75_SCAN_INTERLEAVE_EN selects the interleaved row order in
//           hub75_row_seq; nothing in this package depends on it.

package hub75_scan_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_PAINT = 2'd3;

    // start: begin a new frame (latch row count, row 0)
    // step : advance to the next row of the frame (issued in PAINT)
    typedef struct packed {
        logic start;
        logic step;
    } row_ctrl_t;

endpackage

// File: rtl/hub75_scan_seq_if.sv
// rtl/hub75_scan_seq_if.sv - panel-side handshake bundle of the row scan sequencer
//
// Purpose : groups the BCM painter and frame-buffer readout handshakes.
// Signals : bcm_row/bcm_go/bcm_rdy      - paint request to the BCM block
//           fb_row_addr/fb_row_load/fb_row_rdy - back-buffer preload
//           fb_row_swap                  - front/back buffer swap strobe
// Modports: master = sequencer, slave = BCM / frame-buffer side.

interface hub75_scan_seq_if #(
    parameter int LOG_N_ROWS = 5
);
    logic [LOG_N_ROWS-1:0] bcm_row;
    logic                  bcm_go;
    logic                  bcm_rdy;
    logic [LOG_N_ROWS-1:0] fb_row_addr;
    logic                  fb_row_load;
    logic                  fb_row_rdy;
    logic                  fb_row_swap;

    modport master (
        output bcm_row, bcm_go, fb_row_addr, fb_row_load, fb_row_swap,
        input  bcm_rdy, fb_row_rdy
    );

    modport slave (
        input  bcm_row, bcm_go, fb_row_addr, fb_row_load, fb_row_swap,
        output bcm_rdy, fb_row_rdy
    );
endinterface

// File: rtl/hub75_row_seq.sv
// rtl/hub75_row_seq.sv - row register, row-count clamp and last-row detection
//
// Purpose : holds the current row, the per-frame row count rows_q and
//           computes the last-row flag for the sequencer FSM.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           start         - frame start: latch clamped cfg_rows, row 0
//           step          - advance to the next row (wraps to 0 after last)
//           cfg_rows      - requested row count (0 or > N_ROWS means N_ROWS)
//           row           - current row index
//           last          - current row is the final row of the frame
// Config  : HUB75_SCAN_INTERLEAVE_EN defined -> order 0,2,4..,1,3,5..;
//           undefined -> linear order 0..rows_q-1 and no phase bit.

import hub75_scan_seq_pkg::*;

module hub75_row_seq #(
    parameter int N_ROWS     = 32,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic [LOG_N_ROWS:0]   cfg_rows,
    output logic [LOG_N_ROWS-1:0] row,
    output logic                  last
);

    localparam logic [LOG_N_ROWS:0]   N_ROWS_W = N_ROWS[LOG_N_ROWS:0];
    localparam logic [LOG_N_ROWS:0]   ONE_W    = 1;
    localparam logic [LOG_N_ROWS-1:0] ROW_ZERO = '0;

    logic [LOG_N_ROWS:0]   rows_q, rows_d;
    logic [LOG_N_ROWS:0]   rows_clamped;
    logic [LOG_N_ROWS-1:0] row_q, row_d;
    logic [LOG_N_ROWS:0]   row_ext;

    assign row_ext      = {1'b0, row_q};
    assign rows_clamped = ((cfg_rows == '0) || (cfg_rows > N_ROWS_W)) ? N_ROWS_W : cfg_rows;
    assign row          = row_q;

`ifdef HUB75_SCAN_INTERLEAVE_EN
    localparam logic [LOG_N_ROWS:0]   TWO_W   = 2;
    localparam logic [LOG_N_ROWS-1:0] ROW_ONE = 1;

    logic                phase_q, phase_d;
    logic [LOG_N_ROWS:0] row_p2;

    // row+2 cannot overflow: row <= N_ROWS-1, so row+2 < 2*N_ROWS
    assign row_p2 = row_ext + TWO_W;

    // The frame ends on the final odd row; a one-row frame has no odd phase.
    assign last = (rows_q == ONE_W) || (phase_q && !(row_p2 < rows_q));

    always_comb begin
        rows_d  = rows_q;
        row_d   = row_q;
        phase_d = phase_q;
        if (start) begin
            rows_d  = rows_clamped;
            row_d   = ROW_ZERO;
            phase_d = 1'b0;
        end else if (step) begin
            if (last) begin
                row_d   = ROW_ZERO;
                phase_d = 1'b0;
            end else if (row_p2 < rows_q) begin
                row_d = row_p2[LOG_N_ROWS-1:0];
            end else begin
                // even phase exhausted: continue with the odd rows
                row_d   = ROW_ONE;
                phase_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q  <= N_ROWS_W;
            row_q   <= ROW_ZERO;
            phase_q <= 1'b0;
        end else begin
            rows_q  <= rows_d;
            row_q   <= row_d;
            phase_q <= phase_d;
        end
    end
`else
    logic [LOG_N_ROWS:0] row_p1;

    assign row_p1 = row_ext + ONE_W;
    assign last   = (row_p1 == rows_q);

    always_comb begin
        rows_d = rows_q;
        row_d  = row_q;
        if (start) begin
            rows_d = rows_clamped;
            row_d  = ROW_ZERO;
        end else if (step) begin
            row_d = last ? ROW_ZERO : row_p1[LOG_N_ROWS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q <= N_ROWS_W;
            row_q  <= ROW_ZERO;
        end else begin
            rows_q <= rows_d;
            row_q  <= row_d;
        end
    end
`endif

endmodule

// File: rtl/hub75_scan_seq.sv
// rtl/hub75_scan_seq.sv - HUB75 row scan sequencer (top)
//
// Purpose : walks the rows of a frame, preloading each row into the
//           frame-buffer back-buffer, then swapping buffers and firing the
//           BCM painter. Supports single-shot and continuous loop operation
//           with a stop-at-frame-end request, a frame counter and a
//           frame-end strobe.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           cfg_rows                  - active rows, sampled at frame start
//           ctrl_go / ctrl_rdy        - start request (IDLE only) / idle flag
//           ctrl_loop                 - level: restart after the last row
//           ctrl_stop                 - pulse: finish frame, then IDLE
//           pnl (hub75_scan_seq_if.master) - BCM and frame-buffer handshakes
//           frame_end                 - strobe in PAINT of the last row
//           frame_cnt                 - completed frames, wrapping
// Config  : HUB75_SCAN_INTERLEAVE_EN selects interleaved row order (see
//           hub75_row_seq).

import hub75_scan_seq_pkg::*;

module hub75_scan_seq #(
    parameter int N_ROWS      = 32,
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LOG_N_ROWS:0]    cfg_rows,
    input  logic                   ctrl_go,
    input  logic                   ctrl_loop,
    input  logic                   ctrl_stop,
    output logic                   ctrl_rdy,
    hub75_scan_seq_if.master       pnl,
    output logic                   frame_end,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]             state_q, state_d;
    logic                   stop_q, stop_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    row_ctrl_t              rc;
    logic [LOG_N_ROWS-1:0]  row;
    logic                   last;

    hub75_row_seq #(
        .N_ROWS     (N_ROWS),
        .LOG_N_ROWS (LOG_N_ROWS)
    ) u_row_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (rc.start),
        .step     (rc.step),
        .cfg_rows (cfg_rows),
        .row      (row),
        .last     (last)
    );

    always_comb begin
        state_d  = state_q;
        rc       = '0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_go) begin
                    state_d  = ST_LOAD;
                    rc.start = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pnl.bcm_rdy && pnl.fb_row_rdy) begin
                    state_d = ST_PAINT;
                end
            end
            ST_PAINT: begin
                rc.step = 1'b1;
                if (!last) begin
                    state_d = ST_LOAD;
                end else if (ctrl_loop && !stop_q && !ctrl_stop) begin
                    // loop restart re-samples cfg_rows like a fresh go
                    state_d  = ST_LOAD;
                    rc.start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A stop seen alongside go in IDLE survives into the frame, so that
    // frame ends in IDLE even with ctrl_loop held high.
    assign stop_d = (state_d == ST_IDLE) ? 1'b0 : (stop_q || ctrl_stop);

    assign frame_end = (state_q == ST_PAINT) && last;
    assign cnt_d     = frame_end ? (cnt_q + CNT_ONE) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl_rdy        = (state_q == ST_IDLE);
    assign frame_cnt       = cnt_q;
    assign pnl.fb_row_load = (state_q == ST_LOAD);
    assign pnl.bcm_go      = (state_q == ST_PAINT);
    assign pnl.fb_row_swap = (state_q == ST_PAINT);
    assign pnl.bcm_row     = row;
    assign pnl.fb_row_addr = row;

endmodule
